// File: rtl/ram_pkg.sv
// ---------------------------------------------------------------------------
// ram_pkg
//   Shared constants for the multi-read-port RAM family.
//   - READ_FIRST / WRITE_FIRST select what a read port returns when it reads
//     the word that is being written on the same clock edge.
//   - ST_READY / ST_CLEAR are the clear sequencer state codes. They are kept
//     as plain logic constants so older blocks that compare raw state bits
//     keep working.
//   - idx_width() gives the number of address bits that actually index the
//     storage array, which can be fewer than the port address width.
// ---------------------------------------------------------------------------
package ram_pkg;

  localparam int READ_FIRST  = 0;
  localparam int WRITE_FIRST = 1;

  localparam logic [0:0] ST_READY = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  // Bits needed to index 'depth' words; a one-word array still needs one bit
  // so that slices stay legal.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ram_clear_sequencer.sv
// ---------------------------------------------------------------------------
// ram_clear_sequencer
//   Owns the READY/CLEAR state machine of the RAM. While in CLEAR it issues
//   one write per cycle, sweeping the address from 0 to MEM_DEPTH-1, and it
//   generates the registered ready flag that gates user reads and writes.
//
// Ports
//   Clock          in   system clock, rising edge
//   Reset          in   asynchronous active-low reset
//   iClear         in   single-cycle request to start a sweep (READY only)
//   oReady         out  high when the RAM accepts user reads and writes
//   oClearWrite    out  high while the sweep owns the array write port
//   oClearAddress  out  word currently being written by the sweep
// ---------------------------------------------------------------------------
module ram_clear_sequencer
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int MEM_DEPTH      = 256,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iClear,
  output logic                  oReady,
  output logic                  oClearWrite,
  output logic [ADDR_WIDTH-1:0] oClearAddress
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [0:0]            RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
  localparam logic                  RESET_READY = (CLEAR_ON_RESET == 0);

  logic [0:0]            state;
  logic                  ready;
  logic [ADDR_WIDTH-1:0] clear_addr;

  // State machine and sweep counter. The ready flag is a register of its own
  // rather than a decode of the state so that it changes exactly one cycle
  // after the request and one cycle after the final sweep write. A request
  // arriving while a sweep is running is ignored; the sweep never restarts
  // except through reset.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state      <= RESET_STATE;
      ready      <= RESET_READY;
      clear_addr <= '0;
    end else begin
      case (state)
        ST_READY: begin
          if (iClear) begin
            state      <= ST_CLEAR;
            ready      <= 1'b0;
            clear_addr <= '0;
          end
        end
        ST_CLEAR: begin
          if (clear_addr == LAST_ADDR) begin
            state      <= ST_READY;
            ready      <= 1'b1;
            clear_addr <= '0;
          end else begin
            clear_addr <= clear_addr + 1'b1;
          end
        end
        default: begin
          state      <= ST_READY;
          ready      <= 1'b1;
          clear_addr <= '0;
        end
      endcase
    end
  end

  // Every CLEAR cycle writes exactly one word, so the strobe is the state.
  assign oClearWrite   = (state == ST_CLEAR);
  assign oClearAddress = clear_addr;
  assign oReady        = ready;

endmodule

// File: rtl/ram_multi_read_port.sv
// ---------------------------------------------------------------------------
// ram_multi_read_port
//   Synchronous RAM with one write port and NUM_READ_PORTS independent,
//   registered read ports. A clear sequencer can sweep MEM_INIT into every
//   word after reset or on request; while it runs the RAM is not ready and
//   user accesses are refused.
//
// Ports
//   Clock          in   system clock, rising edge
//   Reset          in   asynchronous active-low reset
//   iClear         in   single-cycle request to start a clear sweep
//   iWriteEnable   in   write strobe
//   iWriteAddress  in   write address
//   iDataIn        in   write data
//   iReadEnable    in   per-port read strobe
//   iReadAddress   in   packed read addresses, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   oDataOut       out  packed registered read data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
//   oReadValid     out  per-port pulse: that oDataOut slice was loaded this cycle
//   oReady         out  high when the RAM accepts reads and writes
//   oWriteError    out  one-cycle pulse after a write was dropped
// ---------------------------------------------------------------------------
module ram_multi_read_port
  import ram_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 16,
  parameter int                    ADDR_WIDTH     = 8,
  parameter int                    MEM_DEPTH      = 256,
  parameter int                    NUM_READ_PORTS = 2,
  parameter int                    READ_MODE      = READ_FIRST,
  parameter logic [DATA_WIDTH-1:0] MEM_INIT       = '0,
  parameter int                    CLEAR_ON_RESET = 1
) (
  input  logic                                 Clock,
  input  logic                                 Reset,
  input  logic                                 iClear,
  input  logic                                 iWriteEnable,
  input  logic [ADDR_WIDTH-1:0]                iWriteAddress,
  input  logic [DATA_WIDTH-1:0]                iDataIn,
  input  logic [NUM_READ_PORTS-1:0]            iReadEnable,
  input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0] iReadAddress,
  output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] oDataOut,
  output logic [NUM_READ_PORTS-1:0]            oReadValid,
  output logic                                 oReady,
  output logic                                 oWriteError
);

  localparam int IDX_W = idx_width(MEM_DEPTH);

  // One extra bit so that a depth of exactly 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] ram [0:MEM_DEPTH-1];

  logic                  ready;
  logic                  clear_write;
  logic [ADDR_WIDTH-1:0] clear_addr;

  logic                  write_in_range;
  logic                  user_write;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  write_error;

  ram_clear_sequencer #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .MEM_DEPTH      (MEM_DEPTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_sequencer (
    .Clock         (Clock),
    .Reset         (Reset),
    .iClear        (iClear),
    .oReady        (ready),
    .oClearWrite   (clear_write),
    .oClearAddress (clear_addr)
  );

  // A user write lands only when the RAM is ready and the address names a
  // real word. Ready is low for the whole sweep, so the sweep and a user
  // write can never both claim the array port and the mux below is a plain
  // priority select.
  assign write_in_range = ({1'b0, iWriteAddress} < DEPTH_LIMIT);
  assign user_write     = iWriteEnable & ready & write_in_range;

  assign mem_we   = clear_write | user_write;
  assign mem_addr = clear_write ? clear_addr : iWriteAddress;
  assign mem_data = clear_write ? MEM_INIT : iDataIn;

  // Storage array. It has no reset on purpose: only the sweep initialises it,
  // which keeps it mappable onto block RAM.
  always_ff @(posedge Clock) begin
    if (mem_we) begin
      ram[mem_addr[IDX_W-1:0]] <= mem_data;
    end
  end

  // Any write strobe that does not turn into a real write is reported one
  // cycle later for exactly one cycle.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      write_error <= 1'b0;
    end else begin
      write_error <= iWriteEnable & ~(ready & write_in_range);
    end
  end

  assign oReady      = ready;
  assign oWriteError = write_error;

  // One fully independent registered read port per iteration. Each port
  // keeps its own data and valid registers and drives only its own slice of
  // the packed outputs.
  for (genvar k = 0; k < NUM_READ_PORTS; k++) begin : g_read
    logic [ADDR_WIDTH-1:0] raddr;
    logic                  in_range;
    logic                  bypass;
    logic [DATA_WIDTH-1:0] next_word;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;

    assign raddr    = iReadAddress[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign in_range = ({1'b0, raddr} < DEPTH_LIMIT);

    // Write-first forwards the incoming word on a same-address collision.
    // Read-first needs nothing extra: the array still holds the old word
    // when this port samples it on the colliding edge.
    assign bypass = (READ_MODE == WRITE_FIRST) && user_write && (iWriteAddress == raddr);

    // Out-of-range addresses read as zero instead of aliasing onto a real
    // word through the truncated array index.
    always_comb begin
      next_word = '0;
      if (in_range) begin
        next_word = bypass ? iDataIn : ram[raddr[IDX_W-1:0]];
      end
    end

    // Data holds between reads; valid is a single-cycle pulse per read.
    always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else if (iReadEnable[k] && ready) begin
        data_q  <= next_word;
        valid_q <= 1'b1;
      end else begin
        valid_q <= 1'b0;
      end
    end

    assign oDataOut[k*DATA_WIDTH +: DATA_WIDTH] = data_q;
    assign oReadValid[k]                        = valid_q;
  end

endmodule
